pmp_csr_unit: RTL and testbench

- CSR-side owner of the physical memory protection state: holds the pmpcfg/pmpaddr registers and serves M-mode CSR reads and writes.
- Enforces WARL and lock rules on every write.
- Sequentially decodes each entry's OFF/TOR/NA4/NAPOT mode into inclusive word-address ranges, then drives the PMP interface consumed by every pmp_checker instance.
- While a decode is in progress, asserts busy so the core holds memory issue.

---
 rtl/pmp_csr_unit_if.sv | 15 +
 rtl/pmp_csr_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_pmp_csr_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmp_csr_unit_if.sv
// CSR access bus between the core's CSR file (master) and pmp_csr_unit (slave).
// Handshake: csr_wr/csr_rd are single-cycle requests, never together; csr_ack pulses exactly one cycle later and csr_rdata is valid only in that cycle.
interface pmp_csr_unit_if #(
    parameter int RV = 64
);
    logic          csr_wr;
    logic          csr_rd;
    logic [11:0]   csr_addr;
    logic [RV-1:0] csr_wdata;
    logic [RV-1:0] csr_rdata;
    logic          csr_ack;

    modport master (output csr_wr, csr_rd, csr_addr, csr_wdata, input csr_rdata, csr_ack);
    modport slave  (input csr_wr, csr_rd, csr_addr, csr_wdata, output csr_rdata, csr_ack);
endinterface

// File: rtl/pmp_csr_unit.sv
// PMP CSR owner: pmpcfg/pmpaddr storage with WARL/lock rules and a one-entry-per-cycle range decoder.
// Optional Smepmp mseccfg (0x747) is built when PMP_SMEPMP_EN is defined.
module pmp_csr_unit #(
    parameter int NPHYS   = 56,
    parameter int NUM_PMP = 5,
    parameter int RV      = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    pmp_csr_unit_if.slave                 csr,
    output logic                          busy,
    output logic [NUM_PMP-1:0]            pmp_valid,
    output logic [NUM_PMP-1:0]            pmp_locked,
    output logic [3*NUM_PMP-1:0]          pmp_prot,
    output logic [NUM_PMP*(NPHYS-2)-1:0]  pmp_start,
    output logic [NUM_PMP*(NPHYS-2)-1:0]  pmp_aend,
    output logic                          mml,
    output logic                          mmwp,
    output logic                          dbg_state
);
    localparam int AW = NPHYS - 2;
    localparam int IW = (NUM_PMP > 1) ? $clog2(NUM_PMP) : 1;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    logic [7:0]       cfg_q  [NUM_PMP];
    logic [AW-1:0]    addr_q [NUM_PMP];
    logic [7:0]       cfg_n  [NUM_PMP];
    logic [AW-1:0]    addr_n [NUM_PMP];
    logic [NUM_PMP:0] tor_lock;
    logic             modify;
    logic             rlb;
    logic             mml_mode;
    logic [RV-1:0]    rd_val;
    logic [RV-1:0]    rdata_q;
    logic             ack_q;
    state_t           state_q, state_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic             scan_en;

    logic [7:0]       cur_cfg;
    logic [AW-1:0]    cur_addr, prev_addr, napot_m, dec_start, dec_end;
    logic             dec_valid;

    logic [NUM_PMP-1:0] valid_q, locked_q;
    logic [2:0]         prot_q  [NUM_PMP];
    logic [AW-1:0]      start_q [NUM_PMP];
    logic [AW-1:0]      aend_q  [NUM_PMP];
    logic               unused_ok;

    function automatic logic [7:0] warl_cfg(input logic [7:0] w, input logic keep_wr);
        logic [7:0] b;
        b = {w[7], 2'b00, w[4:0]};
        if (b[1] && !b[0] && !keep_wr) b[1] = 1'b0;
        return b;
    endfunction

`ifdef PMP_SMEPMP_EN
    logic mml_q, mmwp_q, rlb_q, any_lock;

    always_comb begin
        any_lock = 1'b0;
        for (int e = 0; e < NUM_PMP; e++) any_lock = any_lock | cfg_q[e][7];
    end

    // MML/MMWP are sticky; RLB can only change while nothing is locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mml_q  <= 1'b0;
            mmwp_q <= 1'b0;
            rlb_q  <= 1'b0;
        end else if (csr.csr_wr && csr.csr_addr == 12'h747) begin
            mml_q  <= mml_q | csr.csr_wdata[0];
            mmwp_q <= mmwp_q | csr.csr_wdata[1];
            if (!any_lock) rlb_q <= csr.csr_wdata[2];
        end
    end

    assign rlb      = rlb_q;
    assign mml_mode = mml_q;
    assign mml      = mml_q;
    assign mmwp     = mmwp_q;
`else
    assign rlb      = 1'b0;
    assign mml_mode = 1'b0;
    assign mml      = 1'b0;
    assign mmwp     = 1'b0;
`endif

    // An address is also frozen when the next entry is a locked TOR using it as its base.
    always_comb begin
        tor_lock[NUM_PMP] = 1'b0;
        for (int e = 0; e < NUM_PMP; e++)
            tor_lock[e] = cfg_q[e][7] && (cfg_q[e][4:3] == A_TOR);
    end

    always_comb begin
        modify = 1'b0;
        for (int e = 0; e < NUM_PMP; e++) begin
            cfg_n[e]  = cfg_q[e];
            addr_n[e] = addr_q[e];
            if (csr.csr_wr) begin
                if (csr.csr_addr == ((e < 8) ? 12'h3A0 : 12'h3A2) && !(cfg_q[e][7] && !rlb))
                    cfg_n[e] = warl_cfg(csr.csr_wdata[8*(e%8) +: 8], mml_mode);
                if (csr.csr_addr == 12'h3B0 + 12'(e) && !((cfg_q[e][7] || tor_lock[e+1]) && !rlb))
                    addr_n[e] = csr.csr_wdata[AW-1:0];
            end
            if (cfg_n[e] != cfg_q[e] || addr_n[e] != addr_q[e]) modify = 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int e = 0; e < NUM_PMP; e++) begin
            if (csr.csr_addr == ((e < 8) ? 12'h3A0 : 12'h3A2)) rd_val[8*(e%8) +: 8] = cfg_q[e];
            if (csr.csr_addr == 12'h3B0 + 12'(e)) rd_val[AW-1:0] = addr_q[e];
        end
`ifdef PMP_SMEPMP_EN
        if (csr.csr_addr == 12'h747) rd_val[2:0] = {rlb_q, mmwp_q, mml_q};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int e = 0; e < NUM_PMP; e++) begin
                cfg_q[e]  <= '0;
                addr_q[e] <= '0;
            end
        end else begin
            ack_q   <= csr.csr_wr || csr.csr_rd;
            rdata_q <= csr.csr_rd ? rd_val : '0;
            for (int e = 0; e < NUM_PMP; e++) begin
                cfg_q[e]  <= cfg_n[e];
                addr_q[e] <= addr_n[e];
            end
        end
    end

    assign csr.csr_ack   = ack_q;
    assign csr.csr_rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        if (modify) begin
            state_n = SCAN;
            idx_n   = '0;
        end else if (state_q == SCAN) begin
            if (idx_q == IW'(NUM_PMP - 1)) begin
                state_n = IDLE;
                idx_n   = '0;
            end else begin
                idx_n = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state_q == SCAN);
        scan_en   = (state_q == SCAN);
        dbg_state = state_q;
    end

    always_comb begin
        cur_cfg   = '0;
        cur_addr  = '0;
        prev_addr = '0;
        for (int e = 0; e < NUM_PMP; e++) begin
            if (idx_q == IW'(e)) begin
                cur_cfg  = cfg_q[e];
                cur_addr = addr_q[e];
            end
        end
        for (int e = 1; e < NUM_PMP; e++)
            if (idx_q == IW'(e)) prev_addr = addr_q[e-1];

        // x ^ (x+1) is the trailing-ones run plus the next bit: the NAPOT size mask.
        napot_m   = cur_addr ^ (cur_addr + 1'b1);
        dec_valid = 1'b0;
        dec_start = '0;
        dec_end   = '0;
        case (cur_cfg[4:3])
            A_TOR: begin
                if (cur_addr > prev_addr) begin
                    dec_valid = 1'b1;
                    dec_start = prev_addr;
                    dec_end   = cur_addr - 1'b1;
                end
            end
            A_NA4: begin
                dec_valid = 1'b1;
                dec_start = cur_addr;
                dec_end   = cur_addr;
            end
            A_NAPOT: begin
                dec_valid = 1'b1;
                dec_start = cur_addr & ~napot_m;
                dec_end   = cur_addr | napot_m;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            locked_q <= '0;
            for (int e = 0; e < NUM_PMP; e++) begin
                prot_q[e]  <= '0;
                start_q[e] <= '0;
                aend_q[e]  <= '0;
            end
        end else if (scan_en) begin
            for (int e = 0; e < NUM_PMP; e++) begin
                if (idx_q == IW'(e)) begin
                    valid_q[e]  <= dec_valid;
                    locked_q[e] <= cur_cfg[7];
                    prot_q[e]   <= cur_cfg[2:0];
                    start_q[e]  <= dec_start;
                    aend_q[e]   <= dec_end;
                end
            end
        end
    end

    assign pmp_valid  = valid_q;
    assign pmp_locked = locked_q;

    for (genvar g = 0; g < NUM_PMP; g++) begin : g_flat
        assign pmp_prot[3*g +: 3]    = prot_q[g];
        assign pmp_start[AW*g +: AW] = start_q[g];
        assign pmp_aend[AW*g +: AW]  = aend_q[g];
    end

    assign unused_ok = ^{csr.csr_wdata, cur_cfg[6:5]};
endmodule

// File: tb/tb_pmp_csr_unit.sv
// Self-checking bench for pmp_csr_unit: directed test-plan steps, then random CSR traffic
// checked against an array-based model of the CSR rules and range decoding.
module tb_pmp_csr_unit;
    localparam int NPHYS   = 56;
    localparam int NUM_PMP = 5;
    localparam int RV      = 64;
    localparam int AW      = NPHYS - 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   busy, mml, mmwp, dbg_state;
    logic [NUM_PMP-1:0]     pmp_valid, pmp_locked;
    logic [3*NUM_PMP-1:0]   pmp_prot;
    logic [NUM_PMP*AW-1:0]  pmp_start, pmp_aend;

    int checks = 0;
    int errors = 0;

    logic [7:0]    cfg_m  [16];
    logic [AW-1:0] addr_m [16];
    bit            mml_m, mmwp_m, rlb_m;

    pmp_csr_unit_if #(.RV(RV)) bus ();

    pmp_csr_unit #(.NPHYS(NPHYS), .NUM_PMP(NUM_PMP), .RV(RV)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr        (bus),
        .busy       (busy),
        .pmp_valid  (pmp_valid),
        .pmp_locked (pmp_locked),
        .pmp_prot   (pmp_prot),
        .pmp_start  (pmp_start),
        .pmp_aend   (pmp_aend),
        .mml        (mml),
        .mmwp       (mmwp),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            cfg_m[i]  = '0;
            addr_m[i] = '0;
        end
        mml_m  = 0;
        mmwp_m = 0;
        rlb_m  = 0;
    endfunction

    function automatic bit model_write(input logic [11:0] a, input logic [63:0] d);
        bit ch;
        int e;
        int n;
        bit lk;
        logic [7:0] nb;
        ch = 0;
        if (a == 12'h3A0 || a == 12'h3A2) begin
            for (int b = 0; b < 8; b++) begin
                e = ((a == 12'h3A2) ? 8 : 0) + b;
                if (e < NUM_PMP && !(cfg_m[e][7] && !rlb_m)) begin
                    nb = d[8*b +: 8];
                    nb[6:5] = 2'b00;
                    if (nb[1] && !nb[0] && !mml_m) nb[1] = 1'b0;
                    if (nb != cfg_m[e]) ch = 1;
                    cfg_m[e] = nb;
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            n = int'(a) - 'h3B0;
            if (n < NUM_PMP) begin
                lk = cfg_m[n][7] || (n + 1 < NUM_PMP && cfg_m[n+1][7] && cfg_m[n+1][4:3] == 2'b01);
                if (!lk || rlb_m) begin
                    if (addr_m[n] != d[AW-1:0]) ch = 1;
                    addr_m[n] = d[AW-1:0];
                end
            end
        end
`ifdef PMP_SMEPMP_EN
        else if (a == 12'h747) begin
            lk = 0;
            for (int i = 0; i < NUM_PMP; i++) lk = lk | cfg_m[i][7];
            mml_m  = mml_m | d[0];
            mmwp_m = mmwp_m | d[1];
            if (!lk) rlb_m = d[2];
        end
`endif
        return ch;
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        logic [63:0] r;
        r = '0;
        if (a == 12'h3A0 || a == 12'h3A2)
            for (int b = 0; b < 8; b++)
                if (((a == 12'h3A2) ? 8 : 0) + b < NUM_PMP) r[8*b +: 8] = cfg_m[((a == 12'h3A2) ? 8 : 0) + b];
        if (a >= 12'h3B0 && a < 12'h3B0 + NUM_PMP) r = 64'(addr_m[int'(a) - 'h3B0]);
`ifdef PMP_SMEPMP_EN
        if (a == 12'h747) r = {61'b0, rlb_m, mmwp_m, mml_m};
`endif
        return r;
    endfunction

    // Range of entry e as a byte-independent word interval, from the mode rules.
    function automatic void exp_entry(input int e, output bit v, output logic [AW-1:0] s, output logic [AW-1:0] t);
        longint unsigned x, lo, size;
        int k;
        x = 64'(addr_m[e]);
        v = 0;
        s = '0;
        t = '0;
        case (cfg_m[e][4:3])
            2'd1: begin
                lo = (e == 0) ? 64'd0 : 64'(addr_m[e-1]);
                if (x > lo) begin
                    v = 1;
                    s = AW'(lo);
                    t = AW'(x - 1);
                end
            end
            2'd2: begin
                v = 1;
                s = AW'(x);
                t = AW'(x);
            end
            2'd3: begin
                k = 0;
                while (k < AW && x[k]) k++;
                size = 64'd1 << (k + 1);
                v = 1;
                s = AW'((x / size) * size);
                t = AW'((x / size) * size + size - 1);
            end
            default: ;
        endcase
    endfunction

    task automatic check_entries();
        for (int e = 0; e < NUM_PMP; e++) begin
            bit v;
            logic [AW-1:0] s, t;
            exp_entry(e, v, s, t);
            check($sformatf("valid%0d", e), 64'(pmp_valid[e]), 64'(v));
            check($sformatf("prot%0d", e), 64'(pmp_prot[3*e +: 3]), 64'(cfg_m[e][2:0]));
            check($sformatf("locked%0d", e), 64'(pmp_locked[e]), 64'(cfg_m[e][7]));
            if (v) begin
                check($sformatf("start%0d", e), 64'(pmp_start[AW*e +: AW]), 64'(s));
                check($sformatf("aend%0d", e), 64'(pmp_aend[AW*e +: AW]), 64'(t));
            end
        end
        check("mml", 64'(mml), 64'(mml_m));
        check("mmwp", 64'(mmwp), 64'(mmwp_m));
    endtask

    // Called in the ack cycle: busy must be high for exactly NUM_PMP cycles when registers changed.
    task automatic scan_check(input bit ch);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_len", 64'(n), ch ? 64'(NUM_PMP) : 64'd0);
        if (n == 0) begin
            @(posedge clk); #1;
        end
        check("ack_low", 64'(bus.csr_ack), 64'd0);
        check_entries();
    endtask

    task automatic do_write(input logic [11:0] a, input logic [63:0] d, input bit wait_scan);
        bit ch;
        bus.csr_wr    = 1'b1;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        @(posedge clk); #1;
        bus.csr_wr = 1'b0;
        check("wr_ack", 64'(bus.csr_ack), 64'd1);
        check("wr_rdata0", bus.csr_rdata, 64'd0);
        ch = model_write(a, d);
        if (wait_scan) scan_check(ch);
    endtask

    task automatic do_read(input logic [11:0] a);
        logic [63:0] e;
        e = model_read(a);
        bus.csr_rd   = 1'b1;
        bus.csr_addr = a;
        @(posedge clk); #1;
        bus.csr_rd = 1'b0;
        check("rd_ack", 64'(bus.csr_ack), 64'd1);
        check($sformatf("rdata_%03h", a), bus.csr_rdata, e);
        @(posedge clk); #1;
        check("rd_ack_low", 64'(bus.csr_ack), 64'd0);
        check("rdata_low", bus.csr_rdata, 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic logic [63:0] rand_cfg();
        logic [63:0] d;
        for (int b = 0; b < 8; b++) begin
            d[8*b +: 8] = 8'($urandom);
            if ($urandom_range(0, 9) != 0) d[8*b+7] = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 2))
            0: return 64'($urandom_range(0, 'h400));
            1: return {$urandom, $urandom};
            default: return 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 60);
        endcase
    endfunction

    initial begin
        logic [11:0] a;
        logic [63:0] d;
        bus.csr_wr    = 1'b0;
        bus.csr_rd    = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(bus.csr_ack), 64'd0);
        check("rst_rdata", bus.csr_rdata, 64'd0);
        check("rst_valid", 64'(pmp_valid), 64'd0);
        check("rst_locked", 64'(pmp_locked), 64'd0);
        check("rst_prot", 64'(pmp_prot), 64'd0);
        check("rst_start", 64'(|pmp_start), 64'd0);
        check("rst_aend", 64'(|pmp_aend), 64'd0);
        check("rst_mml", 64'(mml), 64'd0);
        check("rst_mmwp", 64'(mmwp), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // NAPOT over 0x3FF
        do_write(12'h3B0, 64'h3FF, 1);
        do_write(12'h3A0, 64'h18, 1);
        check("tp1_valid0", 64'(pmp_valid[0]), 64'd1);
        check("tp1_start0", 64'(pmp_start[AW-1:0]), 64'h0);
        check("tp1_aend0", 64'(pmp_aend[AW-1:0]), 64'h7FF);

        // TOR entry 1
        do_write(12'h3B0, 64'h100, 1);
        do_write(12'h3B1, 64'h200, 1);
        do_write(12'h3A0, 64'h0B00, 1);
        check("tp2_start1", 64'(pmp_start[AW +: AW]), 64'h100);
        check("tp2_aend1", 64'(pmp_aend[AW +: AW]), 64'h1FF);
        check("tp2_model_cfg", model_read(12'h3A0), 64'h0B00);
        do_read(12'h3A0);

        // Empty TOR and W-only WARL
        do_write(12'h3B1, 64'h80, 1);
        check("tp3_valid1", 64'(pmp_valid[1]), 64'd0);
        do_write(12'h3A0, 64'h02, 1);
        do_read(12'h3A0);

        // Lock blocks writes and suppresses scans
        do_write(12'h3A0, 64'h99, 1);
        do_write(12'h3B0, 64'h55, 1);
        do_write(12'h3A0, 64'h00, 1);
        do_read(12'h3A0);
        do_read(12'h3B0);
        do_read(12'h3A1);

        // Restart of a scan in progress
        apply_reset();
        do_write(12'h3B0, 64'h3FF, 0);
        check("rs_busy_i0", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("rs_busy_i1", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("rs_busy_i2", 64'(busy), 64'd1);
        do_write(12'h3A0, 64'h18, 1);

        // Reset in the middle of a scan
        do_write(12'h3B3, 64'h40, 1);
        do_write(12'h3A0, 64'h1000_0000, 1);
        check("mr_valid3", 64'(pmp_valid[3]), 64'd1);
        do_write(12'h3B4, 64'h77, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mr_valid", 64'(pmp_valid), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        model_reset();
        reset = 1'b0;

`ifdef PMP_SMEPMP_EN
        do_write(12'h747, 64'h1, 1);
        check("sm_mml_set", 64'(mml), 64'd1);
        do_write(12'h747, 64'h0, 1);
        check("sm_mml_sticky", 64'(mml), 64'd1);
        do_read(12'h747);
        do_write(12'h3A0, 64'h02, 1);
        do_read(12'h3A0);
`else
        do_write(12'h747, 64'h7, 1);
        check("ns_mml", 64'(mml), 64'd0);
        check("ns_mmwp", 64'(mmwp), 64'd0);
        do_read(12'h747);
`endif

        // Random traffic
        apply_reset();
        for (int it = 0; it < 90; it++) begin
            if (it % 30 == 29) apply_reset();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 12'h3A0;
                4:          a = 12'h3A2;
                5:          a = 12'h3A1;
                9:          a = 12'h747;
                default:    a = 12'h3B0 + 12'($urandom_range(0, 6));
            endcase
            d = (a == 12'h3A0 || a == 12'h3A2) ? rand_cfg() :
                (a == 12'h747) ? 64'($urandom_range(0, 7)) : rand_addr();
            do_write(a, d, 1);
            case ($urandom_range(0, 3))
                0:       do_read(12'h3A0);
                1:       do_read(12'h3B0 + 12'($urandom_range(0, 6)));
                2:       do_read(12'h3A2);
                default: do_read(12'h747);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
